// File: rtl/network_tx_arbiter_pkg.sv
// network_tx_pkg: shared state encoding and constants for the UDP transmit arbiter
package network_tx_pkg;
  typedef enum logic [1:0] {IDLE, STREAM, WAIT_TX, GAP} tx_arb_state_t;
  localparam int RMII_IFG_CYCLES = 48;
  localparam int UDP_WORD_W = 16;
endpackage

// File: rtl/network_tx_arbiter_if.sv
// network_tx_arbiter_if: requester-side payload handshake shared by all sources
interface network_tx_arbiter_if #(parameter int NUM_REQ = 2);
  import network_tx_pkg::*;
  logic [NUM_REQ-1:0] valid;
  logic [NUM_REQ-1:0] last;
  logic [NUM_REQ-1:0] ready;
  logic [NUM_REQ*UDP_WORD_W-1:0] data;
  logic [NUM_REQ*UDP_WORD_W-1:0] dst_port;
  modport master (output valid, last, data, dst_port, input ready);
  modport slave (input valid, last, data, dst_port, output ready);
endinterface

// File: rtl/network_tx_arbiter_rr_picker.sv
// rr_picker: first set request at or after the round-robin pointer, wrapping
module rr_picker #(
  parameter int N = 2,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         found,
  output logic [W-1:0] idx
);
  always_comb begin
    idx = ptr;
    for (int k = N - 1; k >= 0; k--)
      if (req[(int'(ptr) + k) % N]) idx = W'((int'(ptr) + k) % N);
  end
  assign found = |req;
endmodule

// File: rtl/network_tx_arbiter.sv
// network_tx_arbiter: round-robin UDP tx arbiter; `TX_ARB_STATS_EN adds frame_cnt/drop_cnt outputs
module network_tx_arbiter
  import network_tx_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int MAX_WORDS = 64,
  parameter int IFG_CYCLES = RMII_IFG_CYCLES,
  parameter int START_TIMEOUT = 1024,
  localparam int GW = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  network_tx_arbiter_if.slave   req,
  input  logic                  eth_txen,
  output logic                  stack_axiiv,
  output logic [UDP_WORD_W-1:0] stack_axiid,
  output logic [UDP_WORD_W-1:0] stack_dst_port,
  output logic [GW-1:0]         grant_id,
  output logic                  busy,
  output logic                  err_underrun,
  output logic                  err_timeout
`ifdef TX_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0] frame_cnt,
  output logic [15:0]           drop_cnt
`endif
);
  localparam int WW = $clog2(MAX_WORDS + 1);
  localparam int TW = $clog2((START_TIMEOUT > IFG_CYCLES ? START_TIMEOUT : IFG_CYCLES) + 1);
  tx_arb_state_t state, next;
  logic [GW-1:0] rr, pick;
  logic found, seen, accept, last_word, underrun, timeout, sent;
  logic [WW-1:0] wcnt;
  logic [TW-1:0] tcnt;
  logic [NUM_REQ-1:0] ready;
  rr_picker #(.N(NUM_REQ)) u_pick (.req(req.valid), .ptr(rr), .found(found), .idx(pick));
  assign accept = state == STREAM && req.valid[grant_id];
  assign last_word = req.last[grant_id] || wcnt == WW'(MAX_WORDS - 1);
  assign busy = state != IDLE;
  assign req.ready = ready;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= next;
  always_comb begin
    next = state;
    ready = '0;
    underrun = 1'b0;
    timeout = 1'b0;
    sent = 1'b0;
    case (state)
      IDLE: next = found ? STREAM : IDLE;
      STREAM: begin
        ready[grant_id] = req.valid[grant_id];
        underrun = !req.valid[grant_id];
        next = underrun || last_word ? WAIT_TX : STREAM;
      end
      WAIT_TX: begin
        sent = seen && !eth_txen;
        timeout = !seen && !eth_txen && tcnt == TW'(START_TIMEOUT - 1);
        next = sent || timeout ? GAP : WAIT_TX;
      end
      default: next = !eth_txen && tcnt == TW'(IFG_CYCLES - 1) ? IDLE : GAP;
    endcase
  end
  // tcnt doubles as start-timeout timer in WAIT_TX and gap timer in GAP
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      stack_axiiv <= 1'b0;
      stack_axiid <= '0;
      stack_dst_port <= '0;
      grant_id <= '0;
      err_underrun <= 1'b0;
      err_timeout <= 1'b0;
      seen <= 1'b0;
      rr <= '0;
      wcnt <= '0;
      tcnt <= '0;
    end else begin
      stack_axiiv <= accept;
      err_underrun <= underrun;
      err_timeout <= timeout;
      seen <= state == WAIT_TX && (seen || eth_txen);
      tcnt <= next != state || (state == GAP && eth_txen) ? '0 :
              state == GAP || (state == WAIT_TX && !seen) ? tcnt + 1'b1 : tcnt;
      if (accept) begin
        stack_axiid <= req.data[grant_id*UDP_WORD_W +: UDP_WORD_W];
        wcnt <= wcnt == WW'(MAX_WORDS) ? wcnt : wcnt + 1'b1;
      end
      if (state == IDLE && found) begin
        grant_id <= pick;
        stack_dst_port <= req.dst_port[pick*UDP_WORD_W +: UDP_WORD_W];
        wcnt <= '0;
      end
      if (state == GAP && next == IDLE) rr <= grant_id == GW'(NUM_REQ - 1) ? '0 : grant_id + 1'b1;
    end
`ifdef TX_ARB_STATS_EN
  logic truncate;
  assign truncate = accept && !req.last[grant_id] && wcnt == WW'(MAX_WORDS - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      frame_cnt <= '0;
      drop_cnt <= '0;
    end else begin
      if (sent) frame_cnt[grant_id*16 +: 16] <= frame_cnt[grant_id*16 +: 16] + 1'b1;
      if ((underrun || timeout || truncate) && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
    end
`endif
endmodule
